// File: rtl/pkt_sender.sv
// ---------------------------------------------------------------------------
// pkt_sender
//
// Packet transmitter feeding the sorter input stream. A packet of up to
// 2**AWIDTH words is loaded through a ready/valid load port into an internal
// register array, held until the downstream sorter reports not-busy, and then
// played out as one uninterrupted burst.
//
// Ports:
//   clk_i       clock
//   srst_i      asynchronous active-high reset
//   ld_data_i   word to load
//   ld_val_i    load strobe, word accepted when ld_val_i && ld_ready_o
//   ld_last_i   final word of the packet (qualified by ld_val_i)
//   ld_ready_o  buffer accepting load words
//   busy_i      downstream busy; a new burst may only start while low
//   data_o      stream data
//   sop_o       first word of packet
//   eop_o       last word of packet
//   val_o       qualifies data_o/sop_o/eop_o
//   done_o      one-cycle pulse in the cycle after the eop_o word
// ---------------------------------------------------------------------------
module pkt_sender #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] ld_data_i,
    input  logic              ld_val_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              done_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] wr_ptr_nxt;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] rd_ptr_nxt;
    logic [AWIDTH-1:0] rd_ptr_inc;
    logic [AWIDTH-1:0] len;
    logic [AWIDTH-1:0] len_nxt;
    logic              wr_en;
    logic [DWIDTH-1:0] data_nxt;
    logic              sop_nxt;
    logic              eop_nxt;
    logic              val_nxt;
    logic              done_nxt;

    logic [DWIDTH-1:0] mem [DEPTH];

    assign ld_ready_o = (state == ST_LOAD);
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // Buffer storage carries no reset; its contents only matter once a
    // packet has been loaded.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= ld_data_i;
        end
    end

    // State, pointers and the registered stream outputs.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            data_o <= '0;
            sop_o  <= 1'b0;
            eop_o  <= 1'b0;
            val_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            len    <= len_nxt;
            data_o <= data_nxt;
            sop_o  <= sop_nxt;
            eop_o  <= eop_nxt;
            val_o  <= val_nxt;
            done_o <= done_nxt;
        end
    end

    // Next-state logic. The stream outputs are computed one cycle ahead so
    // that the first word is already on the bus in the first SEND cycle.
    // rd_ptr always holds the address of the word currently on data_o.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        len_nxt    = len;
        wr_en      = 1'b0;
        data_nxt   = '0;
        sop_nxt    = 1'b0;
        eop_nxt    = 1'b0;
        val_nxt    = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            ST_LOAD: begin
                if (ld_val_i) begin
                    wr_en = 1'b1;
                    // A full buffer closes the packet even without ld_last_i,
                    // so the write pointer never wraps inside a packet.
                    if (ld_last_i || (wr_ptr == LAST_ADDR)) begin
                        len_nxt   = wr_ptr;
                        state_nxt = ST_WAIT;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (!busy_i) begin
                    state_nxt  = ST_SEND;
                    rd_ptr_nxt = '0;
                    val_nxt    = 1'b1;
                    sop_nxt    = 1'b1;
                    eop_nxt    = (len == '0);
                    data_nxt   = mem[0];
                end
            end

            ST_SEND: begin
                if (eop_o) begin
                    state_nxt  = ST_LOAD;
                    done_nxt   = 1'b1;
                    rd_ptr_nxt = '0;
                    wr_ptr_nxt = '0;
                end else begin
                    rd_ptr_nxt = rd_ptr_inc;
                    val_nxt    = 1'b1;
                    eop_nxt    = (rd_ptr_inc == len);
                    data_nxt   = mem[rd_ptr_inc];
                end
            end

            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_pkt_sender.sv
// ---------------------------------------------------------------------------
// tb_pkt_sender
//
// Self-checking bench for pkt_sender. Each packet is described by a list of
// words and whether the final word carries ld_last. A reference model decides
// which words the sender will actually keep (up to the last-flagged word or
// the buffer capacity), and the expected burst timing is derived from that.
// ---------------------------------------------------------------------------
module tb_pkt_sender;

    localparam int AWIDTH = 3;
    localparam int DWIDTH = 8;
    localparam int DEPTH  = 2 ** AWIDTH;

    logic              clk_i = 1'b0;
    logic              srst_i;
    logic [DWIDTH-1:0] ld_data_i;
    logic              ld_val_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic              busy_i;
    logic [DWIDTH-1:0] data_o;
    logic              sop_o;
    logic              eop_o;
    logic              val_o;
    logic              done_o;

    int total = 0;
    int bad   = 0;

    logic [DWIDTH-1:0] pkt_words [$];
    logic [DWIDTH-1:0] exp_q     [$];

    pkt_sender #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .ld_data_i (ld_data_i),
        .ld_val_i  (ld_val_i),
        .ld_last_i (ld_last_i),
        .ld_ready_o(ld_ready_o),
        .busy_i    (busy_i),
        .data_o    (data_o),
        .sop_o     (sop_o),
        .eop_o     (eop_o),
        .val_o     (val_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Idle stream: nothing valid, all qualified fields zero.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_val"},  32'(val_o),  32'd0);
        checkOutput({tag, "_data"}, 32'(data_o), 32'd0);
        checkOutput({tag, "_sop"},  32'(sop_o),  32'd0);
        checkOutput({tag, "_eop"},  32'(eop_o),  32'd0);
    endtask

    // Reference model: words are kept in order until one carries ld_last or
    // the buffer is full; anything offered after that is ignored.
    function automatic int buildExpected(input bit use_last);
        int n;
        n = pkt_words.size();
        exp_q = {};
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pkt_words[i]);
            if ((use_last && i == n - 1) || exp_q.size() == DEPTH) break;
        end
        return exp_q.size();
    endfunction

    // Loads pkt_words, holds busy for busy_cycles, then checks the burst.
    // abort_at >= 0 asserts reset while that word index is on the bus.
    task automatic applyStimulus(input int busy_cycles, input bit use_last, input int abort_at);
        int n;
        int acc;
        n   = pkt_words.size();
        acc = buildExpected(use_last);

        for (int i = 0; i < acc; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                ld_val_i  = 1'b0;
                ld_data_i = DWIDTH'($urandom);
                busy_i    = 1'($urandom);
                tick();
                checkOutput("ready_load", 32'(ld_ready_o), 32'd1);
                checkQuiet("load");
            end
            ld_val_i  = 1'b1;
            ld_data_i = pkt_words[i];
            ld_last_i = use_last && (i == n - 1);
            busy_i    = 1'($urandom);
            tick();
        end
        ld_last_i = 1'b0;
        checkOutput("ready_wait", 32'(ld_ready_o), 32'd0);
        checkQuiet("wait_entry");

        // Words beyond the accepted packet are offered while waiting.
        for (int i = acc; i < n; i++) begin
            ld_val_i  = 1'b1;
            ld_data_i = pkt_words[i];
            ld_last_i = use_last && (i == n - 1);
            busy_i    = 1'b1;
            tick();
            checkOutput("ready_stray", 32'(ld_ready_o), 32'd0);
            checkQuiet("stray");
        end
        ld_last_i = 1'b0;

        for (int b = 0; b < busy_cycles; b++) begin
            busy_i    = 1'b1;
            ld_val_i  = 1'($urandom);
            ld_data_i = DWIDTH'($urandom);
            tick();
            checkOutput("ready_busy", 32'(ld_ready_o), 32'd0);
            checkQuiet("busy");
        end

        busy_i   = 1'b0;
        ld_val_i = 1'b0;
        tick();

        for (int k = 0; k < acc; k++) begin
            checkOutput("send_val",  32'(val_o),      32'd1);
            checkOutput("send_data", 32'(data_o),     32'(exp_q[k]));
            checkOutput("send_sop",  32'(sop_o),      32'(k == 0));
            checkOutput("send_eop",  32'(eop_o),      32'(k == acc - 1));
            checkOutput("send_done", 32'(done_o),     32'd0);
            checkOutput("send_rdy",  32'(ld_ready_o), 32'd0);
            if (k == abort_at) begin
                #2;
                srst_i = 1'b1;
                #1;
                checkQuiet("abort");
                checkOutput("abort_done", 32'(done_o),     32'd0);
                checkOutput("abort_rdy",  32'(ld_ready_o), 32'd1);
                tick();
                checkQuiet("abort_hold");
                srst_i = 1'b0;
                tick();
                checkQuiet("abort_after");
                checkOutput("abort_rdy2", 32'(ld_ready_o), 32'd1);
                return;
            end
            // Downstream busy must not stall an ongoing burst.
            busy_i    = 1'($urandom);
            ld_val_i  = 1'($urandom);
            ld_data_i = DWIDTH'($urandom);
            tick();
        end

        checkQuiet("post");
        checkOutput("post_done", 32'(done_o),     32'd1);
        checkOutput("post_rdy",  32'(ld_ready_o), 32'd1);
        busy_i   = 1'b0;
        ld_val_i = 1'b0;
        tick();
        checkOutput("done_pulse", 32'(done_o), 32'd0);
        checkQuiet("idle");
    endtask

    initial begin
        srst_i    = 1'b1;
        ld_data_i = '0;
        ld_val_i  = 1'b0;
        ld_last_i = 1'b0;
        busy_i    = 1'b0;
        repeat (2) tick();
        checkQuiet("reset");
        checkOutput("reset_done", 32'(done_o),     32'd0);
        checkOutput("reset_rdy",  32'(ld_ready_o), 32'd1);
        srst_i = 1'b0;
        tick();

        pkt_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        applyStimulus(0, 1'b1, -1);

        pkt_words = '{8'hA5};
        applyStimulus(0, 1'b1, -1);

        pkt_words = '{8'h01, 8'h02, 8'h03};
        applyStimulus(10, 1'b1, -1);

        // Nine words without ld_last: eight fill the buffer, the ninth is ignored.
        pkt_words = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        applyStimulus(2, 1'b0, -1);

        pkt_words = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        applyStimulus(0, 1'b1, 2);

        pkt_words = '{8'h3C, 8'hC3};
        applyStimulus(0, 1'b1, -1);

        for (int p = 0; p < 24; p++) begin
            int n;
            bit use_last;
            n = $urandom_range(1, DEPTH + 1);
            use_last = (n <= DEPTH) ? 1'($urandom) | (n < DEPTH) : 1'b0;
            pkt_words = {};
            for (int i = 0; i < n; i++) pkt_words.push_back(DWIDTH'($urandom));
            applyStimulus($urandom_range(0, 4), use_last, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
